// File: rtl/sram_pipe_mem.sv
// Single-port synchronous SRAM with valid/ready request/response channels,
// a READ_LATENCY-deep response pipeline and an in-order, credit-guarded response FIFO.
module sram_pipe_mem #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    NUM_WMASKS     = DATA_WIDTH / 8,
    parameter int    ADDR_WIDTH     = 10,
    parameter int    RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int    READ_LATENCY   = 2,
    parameter int    RSP_FIFO_DEPTH = 4,
    parameter int    IZERO          = 0,
    parameter string IFILE          = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_we,
    output logic                  rsp_err
);
    localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);

    typedef struct packed {
        logic                  we;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    generate
        if (READ_LATENCY < 1 || RSP_FIFO_DEPTH < 1) begin : g_bad_cfg
            $fatal(1, "sram_pipe_mem: READ_LATENCY and RSP_FIFO_DEPTH must both be >= 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    // Power-up contents only; reset never touches the array.
    initial begin
        if (IZERO != 0) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem_q[i] = '0;
        end
    end

    logic          rdy_q;
    logic [CW-1:0] out_q, out_d;
    logic          accept, pop, push, in_range;
    rsp_t          stage_in;

    assign req_ready = rdy_q && (out_q < CW'(RSP_FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH);

    always @(posedge clk) begin
        if (accept && req_we && in_range) begin
            for (int k = 0; k < NUM_WMASKS; k++) begin
                if (req_wmask[k]) mem_q[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        stage_in      = '0;
        stage_in.we   = req_we;
        stage_in.err  = !in_range;
        stage_in.data = (in_range && !req_we) ? mem_q[req_addr] : '0;
    end

    logic [READ_LATENCY-1:0] vld_pipe_q;
    rsp_t                    pipe_q [READ_LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    // Payload needs no reset: it is only observed behind its valid bit.
    always_ff @(posedge clk) begin
        pipe_q[0] <= stage_in;
        for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end

    rsp_t          fifo_q [RSP_FIFO_DEPTH];
    rsp_t          head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push = vld_pipe_q[READ_LATENCY-1];
    assign pop  = rsp_valid && rsp_ready;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        out_d    = out_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= pipe_q[READ_LATENCY-1];
    end

    // rdy_q holds off acceptance until the first edge after reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q    <= 1'b0;
            out_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            rdy_q    <= 1'b1;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign head      = fifo_q[rd_ptr_q];
    assign rsp_valid = (cnt_q != '0);
    assign rsp_rdata = rsp_valid ? head.data : '0;
    assign rsp_we    = rsp_valid ? head.we   : 1'b0;
    assign rsp_err   = rsp_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_sram_pipe_mem.sv
// Scoreboard bench for sram_pipe_mem: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_sram_pipe_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rsp_idx = 0;

    always #5 clk = ~clk;

    sram_pipe_mem #(
        .DATA_WIDTH(32), .NUM_WMASKS(4), .ADDR_WIDTH(10), .RAM_DEPTH(1000),
        .READ_LATENCY(2), .RSP_FIFO_DEPTH(4), .IZERO(1), .IFILE("")
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_we(rsp_we), .rsp_err(rsp_err)
    );

    // Handshake completes at the next posedge; inputs are stable from here to there.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected[%0d]: got we=%0b err=%0b data=%h, required no response",
                         rsp_idx, rsp_we, rsp_err, rsp_rdata);
            end else begin
                e = q.pop_front();
                if (rsp_we !== e.we || rsp_err !== e.err || rsp_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp[%0d]: got we=%0b err=%0b data=%h, required we=%0b err=%0b data=%h",
                             rsp_idx, rsp_we, rsp_err, rsp_rdata, e.we, e.err, e.data);
                end
            end
            rsp_idx++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Called at posedge+2; returns at the following posedge+2.
    task automatic try_req(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                           input logic [3:0] m, input exp_t ex, output bit acc);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = m;
        acc       = req_ready;
        @(posedge clk);
        if (acc) q.push_back(ex);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic send(input string nm, input logic we, input logic [9:0] addr,
                        input logic [31:0] wd, input logic [3:0] m, input exp_t ex);
        bit acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) try_req(we, addr, wd, m, ex, acc);
        chk(nm, {31'b0, acc}, 32'd1);
    endtask

    task automatic drain(input string nm);
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk(nm, q.size(), 32'd0);
    endtask

    initial begin
        bit acc;
        int nacc;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;

        // 1. reset and first-read latency
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            @(posedge clk); #2;
        end
        reset = 1'b1;
        #1 chk("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #2;
        chk("ready_after_edge", {31'b0, req_ready}, 32'd1);
        try_req(1'b0, 10'd5, '0, 4'h0, '{1'b0, 1'b0, 32'h0}, acc);
        chk("t1_accept", {31'b0, acc}, 32'd1);
        chk("t1_lat_e0", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #2;
        chk("t1_lat_e1", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #2;
        chk("t1_lat_e2", {31'b0, rsp_valid}, 32'd1);
        drain("t1_drain");

        // 2. byte mask merge
        send("t2_w0", 1'b1, 10'd3, 32'hAABBCCDD, 4'hF, '{1'b1, 1'b0, 32'h0});
        send("t2_w1", 1'b1, 10'd3, 32'h11223344, 4'h5, '{1'b1, 1'b0, 32'h0});
        send("t2_rd", 1'b0, 10'd3, 32'h0,        4'h0, '{1'b0, 1'b0, 32'hAA22CC44});
        drain("t2_drain");

        // 3. back-to-back at full rate
        for (int i = 0; i < 8; i++) begin
            try_req(1'b1, 10'(i), i * 32'h01010101, 4'hF, '{1'b1, 1'b0, 32'h0}, acc);
            chk("t3_w_ready", {31'b0, acc}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            try_req(1'b0, 10'(i), '0, 4'h0, '{1'b0, 1'b0, i * 32'h01010101}, acc);
            chk("t3_r_ready", {31'b0, acc}, 32'd1);
        end
        drain("t3_drain");

        // 4. backpressure: credits cap outstanding at 4
        rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 1; i <= 6; i++) begin
            try_req(1'b0, 10'(i), '0, 4'h0, '{1'b0, 1'b0, i * 32'h01010101}, acc);
            nacc += int'(acc);
        end
        chk("t4_accepted", nacc, 32'd4);
        chk("t4_ready_low", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t4_hold_data", rsp_rdata, 32'h01010101);
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        chk("t4_ready_back", {31'b0, req_ready}, 32'd1);
        chk("t4_next_head", rsp_rdata, 32'h02020202);
        drain("t4_drain");

        // 5. out-of-range accesses
        send("t5_w_oor", 1'b1, 10'd1000, 32'hDEADBEEF, 4'hF, '{1'b1, 1'b1, 32'h0});
        send("t5_r_oor", 1'b0, 10'd1000, 32'h0,        4'h0, '{1'b0, 1'b1, 32'h0});
        send("t5_r_999", 1'b0, 10'd999,  32'h0,        4'h0, '{1'b0, 1'b0, 32'h0});
        drain("t5_drain");

        // 6. reset with responses in flight
        send("t6_w7", 1'b1, 10'd7, 32'h5A5A1234, 4'hF, '{1'b1, 1'b0, 32'h0});
        drain("t6_drain_w");
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            try_req(1'b0, 10'(i), '0, 4'h0, '{1'b0, 1'b0, i * 32'h01010101}, acc);
        repeat (3) begin @(posedge clk); #2; end
        chk("t6_pending", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t6_async_ready", {31'b0, req_ready}, 32'd0);
        q.delete();
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        #1 chk("t6_ready_pre", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #2;
        chk("t6_ready_post", {31'b0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_stale", {31'b0, rsp_valid}, 32'd0);
            @(posedge clk); #2;
        end
        send("t6_r7", 1'b0, 10'd7, 32'h0, 4'h0, '{1'b0, 1'b0, 32'h5A5A1234});
        drain("t6_drain_r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
